rr_arbiter_8: RTL

- Round-robin arbiter that shares one resource among 8 requesters.
- Internally it reuses the codebase's 8-to-3 encoding idea: a one-hot grant is accompanied by a 3-bit encoded grant index.
- Grants are registered and held while the owner keeps its request asserted.
- A configurable hold limit forces the grant to rotate so no requester starves the others.

---
 rtl/rr_arbiter_8.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8
//   Round-robin arbiter sharing one resource among 8 requesters. The grant is
//   registered and stays with its owner while the owner keeps requesting. A
//   hold limit forces rotation so a busy requester cannot starve the others.
//
// Parameters
//   MAX_HOLD     max consecutive cycles one grant may stay asserted (0..255),
//                0 = unlimited
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           arbiter enable; low releases the grant and blocks new ones
//   req[7:0]     request vector, held high while wanting/using the resource
//   gnt[7:0]     one-hot grant, zero when idle
//   gnt_idx[2:0] encoded index of the granted requester, zero when idle
//   gnt_valid    high when gnt is nonzero
//   hold_expired one-cycle pulse after a forced release by MAX_HOLD
// -----------------------------------------------------------------------------
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       hold_expired
);

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         HOLD_EN  = (MAX_HOLD != 0);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] hold_cnt;

   logic       rel_en, rel_req, rel_hold, release_now;
   logic [2:0] search_ptr;
   logic       win_found;
   logic [2:0] win_idx;
   logic [7:0] win_oh;

   // Release causes for the current owner, in priority order en > req > hold.
   always_comb begin
      rel_en      = !en;
      rel_req     = !req[gnt_idx];
      rel_hold    = HOLD_EN && (hold_cnt == HOLD_LIM);
      release_now = (state == GRANT) && (rel_en || rel_req || rel_hold);
   end

   // On a release the search starts just past the old owner, so re-arbitration
   // at the same edge already sees the rotated pointer.
   always_comb begin
      search_ptr = release_now ? (gnt_idx + 3'd1) : ptr;
   end

   // Circular first-set search starting at search_ptr.
   always_comb begin
      logic [2:0] cand;
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 3'd0;
      for (int i = 0; i < 8; i++) begin
         cand = search_ptr + i[2:0];
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      win_oh = 8'd1 << win_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= 3'd0;
         hold_cnt     <= 8'd0;
         gnt          <= 8'd0;
         gnt_idx      <= 3'd0;
         gnt_valid    <= 1'b0;
         hold_expired <= 1'b0;
      end else begin
         hold_expired <= 1'b0;
         case (state)
            IDLE: begin
               if (en && win_found) begin
                  state     <= GRANT;
                  gnt       <= win_oh;
                  gnt_idx   <= win_idx;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= 8'd1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  ptr          <= search_ptr;
                  hold_expired <= rel_hold && !rel_en && !rel_req;
                  if (en && win_found) begin
                     // Back-to-back handoff, possibly to the same owner.
                     gnt       <= win_oh;
                     gnt_idx   <= win_idx;
                     gnt_valid <= 1'b1;
                     hold_cnt  <= 8'd1;
                  end else begin
                     state     <= IDLE;
                     gnt       <= 8'd0;
                     gnt_idx   <= 3'd0;
                     gnt_valid <= 1'b0;
                     hold_cnt  <= 8'd0;
                  end
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
